// File: rtl/obstacle_pkg.sv
// Shared constants, state encoding and X-coordinate type for the obstacle scroller.
package obstacle_pkg;

   localparam int NUM_SLOTS  = 5;
   localparam int X_START    = 640;
   localparam int PIPE_WIDTH = 40;
   localparam int SPACING    = 160;
   localparam int SPEED      = 2;
   localparam int XW         = 11;
   localparam int X_MAX      = X_START + PIPE_WIDTH + (NUM_SLOTS - 1) * SPACING;

   typedef logic [XW-1:0] xcoord_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      OVER = 2'b10
   } state_t;

   // Right edge of slot k at game start.
   function automatic xcoord_t initX(input int k);
      return xcoord_t'(X_START + PIPE_WIDTH + k * SPACING);
   endfunction

endpackage

// File: rtl/mod5_counter.sv
// Three-bit counter that wraps from 4 back to 0; used for the ROM rotation indices.
module mod5_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   output logic [2:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= 3'd0;
      else if (en)
         count <= (count == 3'd4) ? 3'd0 : count + 3'd1;
   end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolls five pipe slots left once per frame, rotating slots, coins and the
// ROM indices each time the leftmost pipe leaves the screen.
module obstacle_scroller
   import obstacle_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        crash,
   input  logic        coin_taken,
   input  logic [2:0]  coin_slot,
   output logic [2:0]  I,
   output logic [2:0]  IC,
   output logic [10:0] XR0,
   output logic [10:0] XR1,
   output logic [10:0] XR2,
   output logic [10:0] XR3,
   output logic [10:0] XR4,
   output logic [4:0]  coin_visible,
   output logic [7:0]  score,
   output logic        pipe_passed,
   output logic        running
);

   if (X_MAX >= 2048) begin : g_xmax_check
      $error("obstacle_scroller: rightmost pipe edge does not fit in 11 bits");
   end

   localparam xcoord_t SPEED_X   = xcoord_t'(SPEED);
   localparam xcoord_t SPACING_X = xcoord_t'(SPACING);

   state_t     state;
   state_t     stateNext;
   logic       doInit;
   logic       doScroll;
   logic       rotate;
   logic [4:0] clearMask;
   logic [4:0] coinMasked;
   xcoord_t    xr [NUM_SLOTS];

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // Crash outranks a coincident frame tick; a start tick only initialises.
   always_comb begin
      stateNext = state;
      doInit    = 1'b0;
      doScroll  = 1'b0;
      clearMask = 5'b00000;
      case (state)
         IDLE, OVER: begin
            if (start) begin
               stateNext = RUN;
               doInit    = 1'b1;
            end
         end
         RUN: begin
            if (coin_taken && coin_slot < 3'd5)
               clearMask = 5'b00001 << coin_slot;
            if (crash)
               stateNext = OVER;
            else if (frame_tick)
               doScroll = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
      rotate     = doScroll && (xr[0] <= SPEED_X);
      coinMasked = coin_visible & ~clearMask;
   end

   // The coin clear uses pre-rotation slot numbering, then the shift applies.
   always_ff @(posedge clk) begin
      if (reset || doInit) begin
         for (int k = 0; k < NUM_SLOTS; k++)
            xr[k] <= initX(k);
         coin_visible <= 5'b11111;
         score        <= 8'd0;
      end else if (rotate) begin
         for (int k = 0; k < NUM_SLOTS - 1; k++)
            xr[k] <= xr[k+1] - SPEED_X;
         xr[NUM_SLOTS-1] <= xr[NUM_SLOTS-1] - SPEED_X + SPACING_X;
         coin_visible    <= {1'b1, coinMasked[4:1]};
         if (score != 8'hFF)
            score <= score + 8'd1;
      end else begin
         if (doScroll)
            for (int k = 0; k < NUM_SLOTS; k++)
               xr[k] <= xr[k] - SPEED_X;
         coin_visible <= coinMasked;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_passed <= 1'b0;
         running     <= 1'b0;
      end else begin
         pipe_passed <= rotate;
         running     <= (stateNext == RUN);
      end
   end

   mod5_counter u_pipe_index (
      .clk   (clk),
      .reset (reset),
      .clear (doInit),
      .en    (rotate),
      .count (I)
   );

   mod5_counter u_coin_index (
      .clk   (clk),
      .reset (reset),
      .clear (doInit),
      .en    (rotate),
      .count (IC)
   );

   assign XR0 = xr[0];
   assign XR1 = xr[1];
   assign XR2 = xr[2];
   assign XR3 = xr[3];
   assign XR4 = xr[4];

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench: scripted game scenarios plus random traffic, compared
// every cycle against a queue-based behavioural model of the scroller.
module tb_obstacle_scroller;

   localparam int X_START    = 640;
   localparam int PIPE_WIDTH = 40;
   localparam int SPACING    = 160;
   localparam int SPEED      = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frameTick = 1'b0;
   logic        start = 1'b0;
   logic        crash = 1'b0;
   logic        coinTaken = 1'b0;
   logic [2:0]  coinSlot = 3'd0;
   logic [2:0]  I;
   logic [2:0]  IC;
   logic [10:0] XR0, XR1, XR2, XR3, XR4;
   logic [4:0]  coinVisible;
   logic [7:0]  score;
   logic        pipePassed;
   logic        running;

   int errors = 0;
   int checks = 0;

   int mXr[$];
   bit mCoin[$];
   int mI, mIc, mScore, mState;
   bit mPassed, mRunning;
   bit modelValid = 1'b0;

   obstacle_scroller dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frameTick),
      .start        (start),
      .crash        (crash),
      .coin_taken   (coinTaken),
      .coin_slot    (coinSlot),
      .I            (I),
      .IC           (IC),
      .XR0          (XR0),
      .XR1          (XR1),
      .XR2          (XR2),
      .XR3          (XR3),
      .XR4          (XR4),
      .coin_visible (coinVisible),
      .score        (score),
      .pipe_passed  (pipePassed),
      .running      (running)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit st, input bit cr, input bit tk,
                                input bit ct, input int cs);
      @(negedge clk);
      reset     = rst;
      start     = st;
      crash     = cr;
      frameTick = tk;
      coinTaken = ct;
      coinSlot  = 3'(cs);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(0, 0, 0, 1, 0, 0);
   endtask

   task automatic modelInit(input bit run);
      mXr   = {};
      mCoin = {};
      for (int k = 0; k < 5; k++) begin
         mXr.push_back(X_START + PIPE_WIDTH + k * SPACING);
         mCoin.push_back(1'b1);
      end
      mI       = 0;
      mIc      = 0;
      mScore   = 0;
      mPassed  = 0;
      mRunning = run;
   endtask

   function automatic int packCoins();
      int v = 0;
      for (int k = 0; k < 5; k++)
         if (mCoin[k]) v |= (1 << k);
      return v;
   endfunction

   // Game model: 0 = idle, 1 = running, 2 = game over.
   always @(posedge clk) begin
      if (reset) begin
         modelInit(0);
         mState     = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         mPassed = 0;
         if (mState != 1) begin
            if (start) begin
               modelInit(1);
               mState = 1;
            end
         end else begin
            if (coinTaken && coinSlot < 5)
               mCoin[coinSlot] = 1'b0;
            if (crash) begin
               mState   = 2;
               mRunning = 0;
            end else if (frameTick) begin
               if (mXr[0] <= SPEED) begin
                  void'(mXr.pop_front());
                  mXr.push_back(mXr[$] + SPACING);
                  void'(mCoin.pop_front());
                  mCoin.push_back(1'b1);
                  mI      = (mI + 1) % 5;
                  mIc     = (mIc + 1) % 5;
                  mScore  = (mScore < 255) ? mScore + 1 : 255;
                  mPassed = 1;
               end
               foreach (mXr[k]) mXr[k] -= SPEED;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("I", int'(I), mI);
         checkOutput("IC", int'(IC), mIc);
         checkOutput("XR0", int'(XR0), mXr[0]);
         checkOutput("XR1", int'(XR1), mXr[1]);
         checkOutput("XR2", int'(XR2), mXr[2]);
         checkOutput("XR3", int'(XR3), mXr[3]);
         checkOutput("XR4", int'(XR4), mXr[4]);
         checkOutput("coin_visible", int'(coinVisible), packCoins());
         checkOutput("score", int'(score), mScore);
         checkOutput("pipe_passed", int'(pipePassed), int'(mPassed));
         checkOutput("running", int'(running), int'(mRunning));
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle();
      checkOutput("rst_XR0", int'(XR0), 680);
      checkOutput("rst_XR1", int'(XR1), 840);
      checkOutput("rst_XR2", int'(XR2), 1000);
      checkOutput("rst_XR3", int'(XR3), 1160);
      checkOutput("rst_XR4", int'(XR4), 1320);
      checkOutput("rst_I", int'(I), 0);
      checkOutput("rst_coin", int'(coinVisible), 31);
      checkOutput("rst_running", int'(running), 0);

      ticks(10);
      idle();
      checkOutput("idle_XR0", int'(XR0), 680);
      checkOutput("idle_running", int'(running), 0);

      applyStimulus(0, 1, 0, 1, 0, 0);
      idle();
      checkOutput("start_XR0", int'(XR0), 680);
      checkOutput("start_running", int'(running), 1);

      ticks(339);
      idle();
      checkOutput("t339_XR0", int'(XR0), 2);
      checkOutput("t339_XR4", int'(XR4), 642);
      checkOutput("t339_I", int'(I), 0);

      ticks(1);
      idle();
      checkOutput("rot1_XR0", int'(XR0), 160);
      checkOutput("rot1_XR3", int'(XR3), 640);
      checkOutput("rot1_XR4", int'(XR4), 800);
      checkOutput("rot1_I", int'(I), 1);
      checkOutput("rot1_score", int'(score), 1);
      checkOutput("rot1_pulse", int'(pipePassed), 1);
      idle();
      checkOutput("rot1_pulse_end", int'(pipePassed), 0);

      for (int r = 2; r <= 5; r++) begin
         ticks(80);
         idle();
         checkOutput($sformatf("rot%0d_I", r), int'(I), r % 5);
         checkOutput($sformatf("rot%0d_IC", r), int'(IC), r % 5);
      end
      checkOutput("refill_coin", int'(coinVisible), 31);

      applyStimulus(0, 0, 0, 0, 1, 2);
      idle();
      checkOutput("coin2_clear", int'(coinVisible), 5'b11011);
      ticks(79);
      applyStimulus(0, 0, 0, 1, 1, 1);
      idle();
      checkOutput("coin_rotate", int'(coinVisible), 5'b11100);

      ticks(10);
      applyStimulus(0, 0, 1, 1, 0, 0);
      idle();
      checkOutput("crash_XR0", int'(XR0), 140);
      checkOutput("crash_running", int'(running), 0);
      ticks(5);
      idle();
      checkOutput("over_XR0", int'(XR0), 140);

      applyStimulus(0, 1, 0, 0, 0, 0);
      idle();
      checkOutput("restart_XR0", int'(XR0), 680);
      checkOutput("restart_score", int'(score), 0);
      checkOutput("restart_running", int'(running), 1);
      ticks(140);
      idle();
      checkOutput("pre_crash_XR0", int'(XR0), 400);
      applyStimulus(0, 0, 1, 1, 0, 0);
      idle();
      checkOutput("crash400_XR0", int'(XR0), 400);

      applyStimulus(0, 1, 0, 0, 0, 0);
      ticks(20739);
      idle();
      checkOutput("sat_score", int'(score), 255);
      ticks(1);
      idle();
      checkOutput("sat_score_hold", int'(score), 255);
      checkOutput("sat_pulse", int'(pipePassed), 1);

      applyStimulus(1, 0, 0, 1, 0, 0);
      idle();
      checkOutput("midreset_XR0", int'(XR0), 680);
      checkOutput("midreset_score", int'(score), 0);
      checkOutput("midreset_running", int'(running), 0);

      for (int n = 0; n < 6000; n++) begin
         applyStimulus(($urandom_range(499) == 0), ($urandom_range(39) == 0),
                       ($urandom_range(149) == 0), ($urandom_range(1) == 0),
                       ($urandom_range(9) == 0), int'($urandom_range(7)));
      end
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
